// File: rtl/instr_fetch.sv
// instr_fetch: fetch initiator that drives the PC into the IRAM and hands each instruction to the decoder.
// Latency: start edge -> instr_valid after 2 more edges; one fetch in flight, 1 instr / 3 cycles at full rate.
// Backpressure: HOLD keeps instr_data/instr_pc/pc_out frozen while instr_ready is low.
// Optional feature macro: FETCH_HALT_OPC_EN (halt opcode terminates the program on its handshake).
module instr_fetch #(
  parameter int          PC_W     = 7,
  parameter int          INSTR_W  = 20,
  parameter int          START_PC = 0,
  parameter int          LAST_PC  = 49
`ifdef FETCH_HALT_OPC_EN
  ,
  parameter logic [3:0]  HALT_OPC = 4'hF
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam logic [PC_W-1:0] START_PC_L = PC_W'(START_PC);
  localparam logic [PC_W-1:0] LAST_PC_L  = PC_W'(LAST_PC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      instr_pc_q;
  logic [INSTR_W-1:0]   instr_data_q;
  logic                 instr_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fault_q;

  // Handshake decode and candidate next PC
  logic                 handshake_d;
  logic                 jump_in_range_d;
  logic                 at_last_d;
  logic                 halt_opc_hit_d;
  logic [PC_W-1:0]      pc_seq_d;

  // Decode what the current handshake (if any) should do
  always_comb begin
    handshake_d     = (state_q == S_HOLD) && instr_valid_q && instr_ready;
    jump_in_range_d = (jump_target <= LAST_PC_L);
    at_last_d       = (pc_q == LAST_PC_L);
    pc_seq_d        = pc_q + PC_W'(1);
`ifdef FETCH_HALT_OPC_EN
    halt_opc_hit_d  = (instr_data_q[INSTR_W-1 -: 4] == HALT_OPC);
`else
    halt_opc_hit_d  = 1'b0;
`endif
  end

  // Fetch sequencer: state plus all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_pc_q    <= '0;
      instr_data_q  <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else if (halt) begin
      // Abort wins over everything, including a simultaneous start.
      // Address/data registers and fault are left as they were.
      state_q       <= S_IDLE;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q    <= START_PC_L;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          // IRAM registers pc_out at this edge
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          instr_data_q  <= instr_in;
          instr_pc_q    <= pc_q;
          instr_valid_q <= 1'b1;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (handshake_d) begin
            instr_valid_q <= 1'b0;
            if (halt_opc_hit_d) begin
              // Halt instruction has been delivered; any jump is ignored
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (jump_en) begin
              if (jump_in_range_d) begin
                pc_q    <= jump_target;
                state_q <= S_FETCH;
              end else begin
                // Out-of-range redirect: stop without touching pc_out
                fault_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else if (at_last_d) begin
              // Program end: no wrap, pc_out parks on the last address
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_seq_d;
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered-read IRAM model.
module tb_instr_fetch;
  localparam int PC_W    = 7;
  localparam int INSTR_W = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, halt, instr_ready, jump_en;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    pc_out, instr_pc;
  logic [INSTR_W-1:0] instr_in, instr_data;
  logic               instr_valid, busy, done, fault;

  logic [INSTR_W-1:0] ram [128];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // IRAM: one-cycle registered read
  always @(posedge clk) instr_in <= ram[pc_out];

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .START_PC(0), .LAST_PC(49)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .pc_out(pc_out), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .jump_en(jump_en), .jump_target(jump_target),
    .busy(busy), .done(done), .fault(fault)
  );

  function automatic logic [INSTR_W-1:0] word(input int i);
    return INSTR_W'(32'h10000 + i * 17);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = word(i);
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; jump_target = '0;
    step(); step();
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_data", 32'(instr_data), 0);
    chk("rst_ipc", 32'(instr_pc), 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Sequential fetch, ready tied high
    instr_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk("s0_busy", 32'(busy), 1);
    chk("s0_pc", 32'(pc_out), 0);
    chk("s0_valid", 32'(instr_valid), 0);
    step();
    chk("s1_valid", 32'(instr_valid), 0);
    step();
    chk("i0_valid", 32'(instr_valid), 1);
    chk("i0_pc", 32'(instr_pc), 0);
    chk("i0_data", 32'(instr_data), 32'(word(0)));
    step();
    chk("hs0_valid", 32'(instr_valid), 0);
    chk("hs0_pc", 32'(pc_out), 1);
    step(); step();
    chk("i1_valid", 32'(instr_valid), 1);
    chk("i1_pc", 32'(instr_pc), 1);
    chk("i1_data", 32'(instr_data), 32'(word(1)));
    step(); step(); step();
    chk("i2_pc", 32'(instr_pc), 2);
    chk("i2_data", 32'(instr_data), 32'(word(2)));
    step(); step(); step();
    chk("i3_pc", 32'(instr_pc), 3);

    // Jump at pc 3 -> 9
    jump_en = 1'b1; jump_target = 7'd9;
    step();
    chk("jmp_pc", 32'(pc_out), 9);
    chk("jmp_valid", 32'(instr_valid), 0);
    // jump_en outside a handshake must be ignored
    jump_target = 7'd20;
    step(); step();
    instr_ready = 1'b0;
    chk("i9_pc", 32'(instr_pc), 9);
    chk("i9_data", 32'(instr_data), 32'(word(9)));
    chk("i9_pcout", 32'(pc_out), 9);
    // Backpressure: everything frozen
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_ipc", 32'(instr_pc), 9);
      chk("bp_pcout", 32'(pc_out), 9);
      chk("bp_data", 32'(instr_data), 32'(word(9)));
    end
    instr_ready = 1'b1; jump_en = 1'b0;
    step();
    chk("inc_pc", 32'(pc_out), 10);
    start = 1'b1;            // start while busy: ignored
    step(); start = 1'b0;
    step();
    chk("i10_pc", 32'(instr_pc), 10);
    chk("i10_busy", 32'(busy), 1);

    // Jump to the last valid address, then program end
    jump_en = 1'b1; jump_target = 7'd49;
    step(); jump_en = 1'b0;
    chk("j49_pc", 32'(pc_out), 49);
    step(); step();
    chk("i49_data", 32'(instr_data), 32'(word(49)));
    step();
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_valid", 32'(instr_valid), 0);
    chk("end_pc", 32'(pc_out), 49);
    step();
    chk("end_hold_pc", 32'(pc_out), 49);
    chk("end_hold_done", 32'(done), 1);

    // Restart from DONE, then out-of-range jump
    start = 1'b1;
    step(); start = 1'b0;
    chk("rs_done", 32'(done), 0);
    chk("rs_busy", 32'(busy), 1);
    chk("rs_pc", 32'(pc_out), 0);
    step(); step();
    jump_en = 1'b1; jump_target = 7'd50;
    step(); jump_en = 1'b0;
    chk("flt_fault", 32'(fault), 1);
    chk("flt_done", 32'(done), 1);
    chk("flt_busy", 32'(busy), 0);
    chk("flt_pc", 32'(pc_out), 0);
    step();
    chk("flt_sticky", 32'(fault), 1);
    start = 1'b1;
    step(); start = 1'b0;
    chk("flt_clr", 32'(fault), 0);
    chk("flt_clr_busy", 32'(busy), 1);

    // Halt during WAIT
    step();
    halt = 1'b1;
    step(); halt = 1'b0;
    chk("hw_busy", 32'(busy), 0);
    chk("hw_valid", 32'(instr_valid), 0);
    step(); step();
    chk("hw_stay_valid", 32'(instr_valid), 0);
    chk("hw_stay_busy", 32'(busy), 0);

    // Refetch, jump to 5, halt in HOLD
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("rf_pc", 32'(instr_pc), 0);
    jump_en = 1'b1; jump_target = 7'd5;
    step(); jump_en = 1'b0;
    step(); step();
    instr_ready = 1'b0;
    chk("i5_pc", 32'(instr_pc), 5);
    halt = 1'b1;
    step();
    chk("hh_valid", 32'(instr_valid), 0);
    chk("hh_busy", 32'(busy), 0);
    chk("hh_ipc", 32'(instr_pc), 5);
    chk("hh_data", 32'(instr_data), 32'(word(5)));
    chk("hh_pcout", 32'(pc_out), 5);
    start = 1'b1;             // halt + start together: halt wins
    step();
    halt = 1'b0; start = 1'b0;
    chk("hs_busy", 32'(busy), 0);
    chk("hs_pc", 32'(pc_out), 5);
    step();
    chk("hs_idle", 32'(busy), 0);

    // Async reset mid-fetch
    instr_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    jump_en = 1'b1; jump_target = 7'd7;
    step(); jump_en = 1'b0;
    chk("pre_rst_pc", 32'(pc_out), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_ipc", 32'(instr_pc), 0);
    chk("arst_data", 32'(instr_data), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("arst_idle", 32'(busy), 0);

`ifdef FETCH_HALT_OPC_EN
    // Halt opcode at pc 2 ends the program after delivery
    ram[2] = 20'hF0000;
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    step(); step(); step();
    step(); step(); step();
    chk("ho_data", 32'(instr_data), 32'h000F0000);
    jump_en = 1'b1; jump_target = 7'd20;
    step(); jump_en = 1'b0;
    chk("ho_done", 32'(done), 1);
    chk("ho_pc", 32'(pc_out), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
